// File: rtl/ps2_dev_pkg.sv
// Shared types and helpers for the PS/2 device-side emulator.
// Holds the FSM state enum, frame sizes, ACK byte and odd-parity helper.
package ps2_dev_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX_BIT_HI,
    TX_BIT_LO,
    RX_WAIT,
    RX_BIT_HI,
    RX_BIT_LO,
    RX_ACK,
    GAP
  } state_t;

  localparam int FRAME_TX_BITS = 11;
  localparam int FRAME_RX_BITS = 10;
  localparam logic [7:0] ACK_BYTE = 8'hFA;

  // Cycles after releasing clock before the synced level can be trusted
  localparam int INH_GUARD = 3;

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_device_emu_if.sv
// User-side byte interface of the PS/2 device emulator.
// master = user logic, slave = emulator (tx/rx bytes, status).
interface ps2_device_emu_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       busy;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, rx_err, busy
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, rx_err, busy
  );
endinterface

// File: rtl/ps2_line_sync.sv
// Dual 2-flop synchronizer for the PS/2 clock and data pads.
// Ports: clk, rst_n, clk_in/dat_in raw pads, clk_s/dat_s synced levels.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_in,
  input  logic dat_in,
  output logic clk_s,
  output logic dat_s
);
  logic [1:0] c_q;
  logic [1:0] d_q;

  // Reset to 1: an idle (released) bus reads high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= 2'b11;
      d_q <= 2'b11;
    end else begin
      c_q <= {c_q[0], clk_in};
      d_q <= {d_q[0], dat_in};
    end
  end

  assign clk_s = c_q[1];
  assign dat_s = d_q[1];
endmodule

// File: rtl/ps2_device_emu.sv
// PS/2 device-side endpoint: generates PS/2 clock, sends bytes to the
// host and receives host command bytes with ACK.
// Ports: clk, resetn (async low), ps2_clk_in/ps2_data_in raw pads,
// ps2_clk_oe/ps2_data_oe open-collector pull-downs, bus (byte iface).
// Option: define PS2_DEV_AUTO_ACK_EN to answer each good RX with 8'hFA.
module ps2_device_emu
  import ps2_dev_pkg::*;
#(
  parameter int HALF_PERIOD_CYC = 2000,
  parameter int GAP_CYC         = 4000
) (
  input  logic clk,
  input  logic resetn,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic ps2_clk_oe,
  output logic ps2_data_oe,
  ps2_device_emu_if.slave bus
);
  localparam int HW = $clog2(HALF_PERIOD_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [HW-1:0] H_END = HW'(HALF_PERIOD_CYC - 1);
  localparam logic [HW-1:0] H_GRD = HW'(INH_GUARD);
  localparam logic [GW-1:0] G_END = GW'(GAP_CYC - 1);

`ifdef PS2_DEV_AUTO_ACK_EN
  localparam logic AUTO_ACK = 1'b1;
`else
  localparam logic AUTO_ACK = 1'b0;
`endif

  state_t        state;
  logic [HW-1:0] cnt;
  logic [GW-1:0] gcnt;
  logic [3:0]    bitc;
  logic [7:0]    tx_byte;
  logic          tx_pend;
  logic [9:0]    rx_sh;
  logic          up;
  logic          s_clk;
  logic          s_dat;
  logic [10:0]   frame;
  logic          tx_bit;
  logic          h_done;
  logic          rx_bad;

  ps2_line_sync u_sync (
    .clk    (clk),
    .rst_n  (resetn),
    .clk_in (ps2_clk_in),
    .dat_in (ps2_data_in),
    .clk_s  (s_clk),
    .dat_s  (s_dat)
  );

  assign frame  = {1'b1, odd_par(tx_byte), tx_byte, 1'b0};
  assign tx_bit = frame[bitc];
  assign h_done = (cnt == H_END);
  assign rx_bad = (rx_sh[8] != odd_par(rx_sh[7:0])) | ~rx_sh[9];

  // A pending (aborted or auto-ACK) byte blocks new user bytes
  assign bus.tx_ready = up & (state == IDLE) & s_clk & s_dat & ~tx_pend;
  assign bus.busy     = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      gcnt         <= '0;
      bitc         <= '0;
      tx_byte      <= '0;
      tx_pend      <= 1'b0;
      rx_sh        <= '0;
      up           <= 1'b0;
      ps2_clk_oe   <= 1'b0;
      ps2_data_oe  <= 1'b0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      bus.rx_err   <= 1'b0;
    end else begin
      up           <= 1'b1;
      bus.rx_valid <= 1'b0;
      cnt          <= cnt + HW'(1);
      gcnt         <= '0;
      // Pads follow the current state one cycle later
      ps2_clk_oe  <= (state == TX_BIT_LO) | (state == RX_BIT_LO) |
                     ((state == RX_ACK) & (bitc == 4'd10));
      ps2_data_oe <= (((state == TX_BIT_HI) | (state == TX_BIT_LO)) & ~tx_bit) |
                     (state == RX_ACK);
      unique case (state)
        IDLE: begin
          cnt  <= '0;
          bitc <= '0;
          if (s_clk && !s_dat) begin
            state <= RX_WAIT;
          end else if (s_clk && s_dat && tx_pend) begin
            state <= TX_BIT_HI;
          end else if (bus.tx_ready && bus.tx_valid) begin
            tx_byte <= bus.tx_data;
            tx_pend <= 1'b1;
            state   <= TX_BIT_HI;
          end
        end
        TX_BIT_HI: begin
          if (!s_clk && cnt >= H_GRD) begin
            // Host inhibit: before parity resend later, else done
            cnt  <= '0;
            bitc <= '0;
            if (bitc < 4'd9) begin
              state <= IDLE;
            end else begin
              tx_pend <= 1'b0;
              state   <= GAP;
            end
          end else if (h_done) begin
            cnt   <= '0;
            state <= TX_BIT_LO;
          end
        end
        TX_BIT_LO: begin
          if (h_done) begin
            cnt <= '0;
            if (bitc == 4'd10) begin
              bitc    <= '0;
              tx_pend <= 1'b0;
              state   <= GAP;
            end else begin
              bitc  <= bitc + 4'd1;
              state <= TX_BIT_HI;
            end
          end
        end
        RX_WAIT: begin
          if (h_done) begin
            cnt   <= '0;
            state <= RX_BIT_LO;
          end
        end
        RX_BIT_LO: begin
          if (h_done) begin
            cnt   <= '0;
            state <= RX_BIT_HI;
          end
        end
        RX_BIT_HI: begin
          if (h_done) begin
            cnt   <= '0;
            rx_sh <= {s_dat, rx_sh[9:1]};
            bitc  <= bitc + 4'd1;
            state <= (bitc == 4'd9) ? RX_ACK : RX_BIT_LO;
          end
        end
        RX_ACK: begin
          // bitc 10: clock-low half, then wraps to 0 for the high half
          if (h_done) begin
            cnt <= '0;
            if (bitc == 4'd10) begin
              bitc <= '0;
            end else begin
              state        <= GAP;
              bus.rx_valid <= 1'b1;
              bus.rx_data  <= rx_sh[7:0];
              bus.rx_err   <= rx_bad;
              if (AUTO_ACK && !rx_bad) begin
                tx_byte <= ACK_BYTE;
                tx_pend <= 1'b1;
              end
            end
          end
        end
        GAP: begin
          cnt  <= '0;
          gcnt <= gcnt + GW'(1);
          if (gcnt == G_END) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule
